// File: rtl/adc_capture_ctrl_if.sv
// Byte stream handshake from the capture controller to the UART transmitter.
// The master presents tx_data/tx_valid; the slave answers with tx_ready.
interface adc_capture_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Trigger and capture sequencer for the ADC sample path.
// Arms on request, waits for a threshold crossing on the live sample (or a
// software trigger), records DEPTH delay-line samples and then streams them
// to the UART as bytes, high byte first.
// Optional macro CAPTURE_FRAME_HDR_EN prefixes the stream with a 3-byte
// header (0xA5, 0x5A, trigger source).
module adc_capture_ctrl #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                trig_edge,
    input  logic                force_trig,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [WIDTH-1:0]    sample_live,
    input  logic [WIDTH-1:0]    sample_dly,
    adc_capture_ctrl_if.master  tx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              byte_sel;
    logic              all_loaded;
    logic [WIDTH-1:0]  prev_live;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;

    logic              rise_hit;
    logic              fall_hit;
    logic              trig_hit;
    logic              trigger;
    logic              capture_last;
    logic              xfer;
    logic              finish;
    logic              load_byte;
    logic              mem_we;
    logic              last_byte;
    logic [WIDTH-1:0]  rd_sample;
    logic [15:0]       rd_ext;
    logic [7:0]        sample_byte;
    logic [7:0]        next_byte;

`ifdef CAPTURE_FRAME_HDR_EN
    logic [1:0]        hdr_cnt;
    logic              src_force;
`endif

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort overrides every other event
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm)          next_state = ARMED;
                ARMED:   if (trigger)      next_state = CAPTURE;
                CAPTURE: if (capture_last) next_state = READOUT;
                READOUT: if (finish)       next_state = IDLE;
                default:                   next_state = IDLE;
            endcase
        end
    end

    // Status output, trigger detection, handshake strobes and byte selection
    always_comb begin
        busy         = (state != IDLE);
        rise_hit     = (prev_live < threshold) && (sample_live >= threshold);
        fall_hit     = (prev_live >= threshold) && (sample_live < threshold);
        trig_hit     = trig_edge ? rise_hit : fall_hit;
        trigger      = (state == ARMED) && (trig_hit || force_trig);
        capture_last = (state == CAPTURE) && (wr_ptr == LAST_IDX);
        xfer         = (state == READOUT) && tx_valid_q && tx.tx_ready;
        finish       = xfer && all_loaded;
        load_byte    = (state == READOUT) && !all_loaded && (!tx_valid_q || tx.tx_ready);
        mem_we       = !abort && (trigger || (state == CAPTURE));
        wr_addr      = (state == ARMED) ? '0 : wr_ptr;
        rd_sample    = mem[rd_ptr];
        rd_ext       = 16'(rd_sample);
        sample_byte  = byte_sel ? rd_ext[7:0] : rd_ext[15:8];
`ifdef CAPTURE_FRAME_HDR_EN
        case (hdr_cnt)
            2'd0:    next_byte = 8'hA5;
            2'd1:    next_byte = 8'h5A;
            2'd2:    next_byte = src_force ? 8'h02 : 8'h01;
            default: next_byte = sample_byte;
        endcase
        last_byte = (hdr_cnt == 2'd3) && byte_sel && (rd_ptr == LAST_IDX);
`else
        next_byte = sample_byte;
        last_byte = byte_sel && (rd_ptr == LAST_IDX);
`endif
    end

    // Pointers, trigger history and the registered UART-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_live  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_sel   <= 1'b0;
            all_loaded <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done       <= 1'b0;
`ifdef CAPTURE_FRAME_HDR_EN
            hdr_cnt    <= '0;
            src_force  <= 1'b0;
`endif
        end else begin
            prev_live <= sample_live;
            done      <= 1'b0;
            if (abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                byte_sel   <= 1'b0;
                all_loaded <= 1'b0;
                tx_valid_q <= 1'b0;
`ifdef CAPTURE_FRAME_HDR_EN
                hdr_cnt    <= '0;
`endif
            end else begin
                if (trigger) begin
                    wr_ptr <= ADDR_W'(1);
`ifdef CAPTURE_FRAME_HDR_EN
                    // A simultaneous threshold hit and force_trig reports as a threshold trigger
                    src_force <= !trig_hit;
`endif
                end else if (state == CAPTURE) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end

                if (finish) begin
                    tx_valid_q <= 1'b0;
                    done       <= 1'b1;
                    rd_ptr     <= '0;
                    byte_sel   <= 1'b0;
                    all_loaded <= 1'b0;
`ifdef CAPTURE_FRAME_HDR_EN
                    hdr_cnt    <= '0;
`endif
                end else if (load_byte) begin
                    tx_data_q  <= next_byte;
                    tx_valid_q <= 1'b1;
                    if (last_byte) begin
                        all_loaded <= 1'b1;
                    end
`ifdef CAPTURE_FRAME_HDR_EN
                    if (hdr_cnt != 2'd3) begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                    end else
`endif
                    if (byte_sel) begin
                        byte_sel <= 1'b0;
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                    end else begin
                        byte_sel <= 1'b1;
                    end
                end
            end
        end
    end

    // Capture buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= sample_dly;
        end
    end

endmodule
